// File: rtl/fu_pkg.sv
// Shared definitions for the branch functional unit: compare-op codes and
// the bit positions of the branch control field.
package fu_pkg;

    localparam int unsigned CMP_W        = 3;
    localparam int unsigned CTRL_W       = 4;
    localparam int unsigned CTRL_UNCOND  = 0;
    localparam int unsigned CTRL_CMP_LSB = 1;
    localparam int unsigned CTRL_CMP_MSB = 3;

    localparam logic [CMP_W-1:0] CMP_NONE = 3'd0;
    localparam logic [CMP_W-1:0] CMP_EQ   = 3'd1;
    localparam logic [CMP_W-1:0] CMP_NE   = 3'd2;
    localparam logic [CMP_W-1:0] CMP_LT   = 3'd3;
    localparam logic [CMP_W-1:0] CMP_GE   = 3'd4;
    localparam logic [CMP_W-1:0] CMP_LTU  = 3'd5;
    localparam logic [CMP_W-1:0] CMP_GEU  = 3'd6;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator: decides whether a conditional branch is taken.
module branch_cmp
    import fu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [CMP_W-1:0] op,
    output logic             taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            CMP_EQ:  taken = (a == b);
            CMP_NE:  taken = (a != b);
            CMP_LT:  taken = ($signed(a) <  $signed(b));
            CMP_GE:  taken = ($signed(a) >= $signed(b));
            CMP_LTU: taken = (a <  b);
            CMP_GEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fu_branch_pipe.sv
// Pipelined branch/jump unit: computes target, link PC, taken and misalignment
// in stage 0, then carries the tagged result through LATENCY handshaked stages.
module fu_branch_pipe
    import fu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned IALIGN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_jalr,
    input  logic [CTRL_W-1:0] in_cmp_ctrl,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc_jump,
    output logic [XLEN-1:0]   out_pc_wb,
    output logic              out_is_jump,
    output logic              out_misalign,
    output logic [TAG_W-1:0]  out_tag
);

    // IALIGN is 2 or 4: number of low target bits that must be zero
    localparam int unsigned ALIGN_BITS = (IALIGN == 4) ? 2 : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  pc_jump;
        logic [XLEN-1:0]  pc_wb;
        logic             is_jump;
        logic             misalign;
    } stage_t;

    logic   st_valid [LATENCY];
    stage_t st_data  [LATENCY];
    logic   st_move  [LATENCY];

    logic   taken;
    logic   [XLEN-1:0] base;
    logic   [XLEN-1:0] target;
    stage_t s0_next;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .a     (in_rs1),
        .b     (in_rs2),
        .op    (in_cmp_ctrl[CTRL_CMP_MSB:CTRL_CMP_LSB]),
        .taken (taken)
    );

    // Stage-0 result: everything downstream only moves these bits around
    always_comb begin
        base   = in_jalr ? in_rs1 : in_pc;
        target = in_imm + base;
        if (in_jalr) begin
            target[0] = 1'b0;
        end
        s0_next.tag      = in_tag;
        s0_next.pc_jump  = target;
        s0_next.pc_wb    = in_pc + XLEN'(4);
        s0_next.is_jump  = in_cmp_ctrl[CTRL_UNCOND] | taken;
        s0_next.misalign = s0_next.is_jump & (|target[ALIGN_BITS-1:0]);
    end

    // Stage k may hand its content on when some later stage is empty or the output drains
    always_comb begin
        logic chain;
        chain = out_ready;
        for (int k = int'(LATENCY) - 1; k >= 0; k--) begin
            st_move[k] = chain;
            chain      = chain | ~st_valid[k];
        end
    end

    assign in_ready = ~st_valid[0] | st_move[0];

    for (genvar g = 0; g < int'(LATENCY); g++) begin : g_stage
        if (g == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    st_valid[0] <= 1'b0;
                    st_data[0]  <= '0;
                end else if (flush) begin
                    st_valid[0] <= 1'b0;
                end else if (in_ready) begin
                    st_valid[0] <= in_valid;
                    if (in_valid) begin
                        st_data[0] <= s0_next;
                    end
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    st_valid[g] <= 1'b0;
                    st_data[g]  <= '0;
                end else if (flush) begin
                    st_valid[g] <= 1'b0;
                end else if (~st_valid[g] | st_move[g]) begin
                    st_valid[g] <= st_valid[g-1];
                    if (st_valid[g-1]) begin
                        st_data[g] <= st_data[g-1];
                    end
                end
            end
        end
    end

    assign out_valid    = st_valid[LATENCY-1];
    assign out_tag      = st_data[LATENCY-1].tag;
    assign out_pc_jump  = st_data[LATENCY-1].pc_jump;
    assign out_pc_wb    = st_data[LATENCY-1].pc_wb;
    assign out_is_jump  = st_data[LATENCY-1].is_jump;
    assign out_misalign = st_data[LATENCY-1].misalign;

endmodule

// File: tb/tb_fu_branch_pipe.sv
// Bench for fu_branch_pipe: directed cases plus a random stream, checked
// against an in-order latency-queue model of the unit.
module tb_fu_branch_pipe;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;
    localparam int          LAT   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              v, jalr, fl, ordy;
    logic [3:0]        ctrl;
    logic [XLEN-1:0]   rs1, rs2, imm, pc;
    logic [TAG_W-1:0]  tag;

    logic              in_ready, out_valid, out_is_jump, out_misalign;
    logic [XLEN-1:0]   out_pc_jump, out_pc_wb;
    logic [TAG_W-1:0]  out_tag;

    logic              b_ordy;
    logic              b_in_ready, b_out_valid, b_out_is_jump, b_out_misalign;
    logic [XLEN-1:0]   b_out_pc_jump, b_out_pc_wb;
    logic [TAG_W-1:0]  b_out_tag;

    always #5 clk = ~clk;

    fu_branch_pipe #(.XLEN(XLEN), .LATENCY(LAT), .TAG_W(TAG_W), .IALIGN(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(v), .in_ready(in_ready), .in_jalr(jalr),
        .in_cmp_ctrl(ctrl), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_pc(pc),
        .in_tag(tag), .flush(fl), .out_valid(out_valid), .out_ready(ordy),
        .out_pc_jump(out_pc_jump), .out_pc_wb(out_pc_wb), .out_is_jump(out_is_jump),
        .out_misalign(out_misalign), .out_tag(out_tag)
    );

    fu_branch_pipe #(.XLEN(XLEN), .LATENCY(1), .TAG_W(TAG_W), .IALIGN(2)) u_dut_a2 (
        .clk(clk), .rst(rst), .in_valid(v), .in_ready(b_in_ready), .in_jalr(jalr),
        .in_cmp_ctrl(ctrl), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm), .in_pc(pc),
        .in_tag(tag), .flush(fl), .out_valid(b_out_valid), .out_ready(b_ordy),
        .out_pc_jump(b_out_pc_jump), .out_pc_wb(b_out_pc_wb), .out_is_jump(b_out_is_jump),
        .out_misalign(b_out_misalign), .out_tag(b_out_tag)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  pc_jump;
        logic [XLEN-1:0]  pc_wb;
        logic             is_jump;
        logic             misalign;
        int               ready_at;
    } exp_t;

    exp_t             q[$];
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    bit               prev_stall = 0;
    logic [XLEN-1:0]  s_pj, s_pw;
    logic             s_ij, s_mis;
    logic [TAG_W-1:0] s_tag;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Architectural result of the op currently on the inputs
    function automatic exp_t model(input int ialign);
        exp_t            m;
        logic [XLEN-1:0] base, tgt;
        bit              c;
        base = jalr ? rs1 : pc;
        tgt  = imm + base;
        if (jalr) tgt = tgt - (tgt % 2);
        case (ctrl[3:1])
            3'd1:    c = (rs1 == rs2);
            3'd2:    c = (rs1 != rs2);
            3'd3:    c = ($signed(rs1) <  $signed(rs2));
            3'd4:    c = ($signed(rs1) >= $signed(rs2));
            3'd5:    c = (rs1 <  rs2);
            3'd6:    c = (rs1 >= rs2);
            default: c = 1'b0;
        endcase
        m.tag      = tag;
        m.pc_jump  = tgt;
        m.pc_wb    = pc + 32'd4;
        m.is_jump  = ctrl[0] || c;
        m.misalign = m.is_jump && ((tgt % 32'(ialign)) != 0);
        m.ready_at = 0;
        return m;
    endfunction

    task automatic set_op(input bit j, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] i, input logic [31:0] p, input logic [3:0] t);
        v = 1'b1; jalr = j; ctrl = c; rs1 = a; rs2 = b; imm = i; pc = p; tag = t;
    endtask

    task automatic rand_op();
        jalr = 1'($urandom_range(0, 1));
        ctrl = 4'($urandom_range(0, 15));
        rs1  = $urandom;
        rs2  = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
        imm  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
        pc   = $urandom;
        tag  = 4'($urandom_range(0, 15));
    endtask

    // One clock cycle: check outputs mid-cycle, update the model, advance past the edge
    task automatic tick(output bit acc);
        exp_t e;
        bit   exp_ov;
        @(negedge clk); #1;
        if (prev_stall) begin
            chk("hold_pc_jump", out_pc_jump, s_pj);
            chk("hold_pc_wb", out_pc_wb, s_pw);
            chk("hold_is_jump", 32'(out_is_jump), 32'(s_ij));
            chk("hold_misalign", 32'(out_misalign), 32'(s_mis));
            chk("hold_tag", 32'(out_tag), 32'(s_tag));
        end
        exp_ov = (q.size() > 0) && (cyc >= q[0].ready_at);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(ordy || (q.size() < LAT)));
        acc = v && in_ready && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (out_valid && ordy) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("tag", 32'(out_tag), 32'(e.tag));
                    chk("pc_jump", out_pc_jump, e.pc_jump);
                    chk("pc_wb", out_pc_wb, e.pc_wb);
                    chk("is_jump", 32'(out_is_jump), 32'(e.is_jump));
                    chk("misalign", 32'(out_misalign), 32'(e.misalign));
                end
            end
            if (acc) begin
                e = model(4);
                e.ready_at = cyc + LAT;
                q.push_back(e);
            end
        end
        prev_stall = out_valid && !ordy && !fl;
        s_pj = out_pc_jump; s_pw = out_pc_wb; s_ij = out_is_jump; s_mis = out_misalign; s_tag = out_tag;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic drain();
        bit acc;
        v = 1'b0; fl = 1'b0; ordy = 1'b1;
        for (int n = 0; n < 30 && q.size() > 0; n++) tick(acc);
        tick(acc);
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit   acc;
        exp_t e2;
        int   issued;
        rst = 1'b1; v = 1'b0; fl = 1'b0; ordy = 1'b1; b_ordy = 1'b1;
        jalr = 1'b0; ctrl = '0; rs1 = '0; rs2 = '0; imm = '0; pc = '0; tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_pc_jump", out_pc_jump, 32'd0);
        chk("rst_pc_wb", out_pc_wb, 32'd0);
        chk("rst_is_jump", 32'(out_is_jump), 32'd0);
        chk("rst_misalign", 32'(out_misalign), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // BEQ taken
        set_op(1'b0, 4'b0010, 32'd5, 32'd5, 32'h20, 32'h100, 4'h1);
        tick(acc);
        drain();

        // signed vs unsigned less-than on the same operands
        set_op(1'b0, 4'b0110, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h200, 4'h2);
        tick(acc);
        set_op(1'b0, 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h204, 4'h3);
        tick(acc);
        drain();

        // JALR to an odd base: misaligned only at 4-byte alignment
        set_op(1'b1, 4'b0001, 32'h1003, 32'd0, 32'd0, 32'h300, 4'h4);
        e2 = model(2);
        tick(acc);
        chk("a2_out_valid", 32'(b_out_valid), 32'd1);
        chk("a2_pc_jump", b_out_pc_jump, e2.pc_jump);
        chk("a2_misalign", 32'(b_out_misalign), 32'(e2.misalign));
        chk("a2_tag", 32'(b_out_tag), 32'(e2.tag));
        chk("a2_in_ready", 32'(b_in_ready), 32'd1);
        drain();

        // back-pressure: six ops, consumer stalls three cycles
        issued = 0;
        for (int c = 0; c < 40 && issued < 6; c++) begin
            rand_op();
            v = 1'b1;
            tag = 4'(issued);
            ordy = !(c >= 2 && c < 5);
            tick(acc);
            if (acc) issued++;
        end
        chk("bp_issued", 32'(issued), 32'd6);
        drain();

        // flush with three ops in flight; a same-cycle op must not be taken
        ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_op(); v = 1'b1; tag = 4'(5 + k);
            tick(acc);
        end
        rand_op(); v = 1'b1; tag = 4'h8; fl = 1'b1;
        tick(acc);
        fl = 1'b0; ordy = 1'b1;
        rand_op(); v = 1'b1; tag = 4'h9;
        tick(acc);
        drain();

        // PC wrap
        set_op(1'b0, 4'b0001, 32'd0, 32'd0, 32'd8, 32'hFFFF_FFFC, 4'hA);
        tick(acc);
        drain();

        // random stream with occasional flush
        for (int n = 0; n < 300; n++) begin
            rand_op();
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 39) == 0);
            tick(acc);
        end
        fl = 1'b0;

        // fill the pipe, then reset asynchronously mid-cycle
        ordy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_op(); v = 1'b1;
            tick(acc);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_tag", 32'(out_tag), 32'd0);
        chk("async_rst_pc_jump", out_pc_jump, 32'd0);
        q.delete();
        prev_stall = 0;
        v = 1'b0;
        @(posedge clk); #1;
        cyc++;
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            rand_op();
            v    = ($urandom_range(0, 9) < 8);
            ordy = ($urandom_range(0, 9) < 6);
            tick(acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
